calc_seq: RTL and testbench

- Parametrised successor to the calculator main state machine.
- Takes 4-bit keypad codes qualified by a strobe and builds packed-BCD operands of DIGITS digits.
- Drives a BCD ALU through a start/done handshake instead of fixed latency, and shows the current operand or result on the display bus.
- Adds operator chaining, repeat-equals, digit-limit handling and an error state.

---
 rtl/calc_seq.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_calc_seq.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq.sv
// ---------------------------------------------------------------------------
// calc_seq
// Keypad-driven calculator sequencer. Assembles packed-BCD operands from key
// strobes, hands complete operations to an external BCD ALU with a
// start/done handshake, and drives the display with the current operand,
// the last result, or an error pattern. Supports operator chaining,
// repeat-equals, a per-operand digit limit and a sticky error state.
//
// Parameters:
//   DIGITS   - BCD digits per operand/result/display (W = 4*DIGITS)
//   ERR_CODE - display pattern shown while in the error state
//   TIMEOUT  - ALU watchdog limit in cycles (optional feature only)
//
// Optional feature macro: CALC_SEQ_TIMEOUT_EN
//   Defined   : a watchdog in WAIT_ALU forces ERROR after TIMEOUT cycles
//               without ALUdone; the late ALUdone is drained.
//   Undefined : WAIT_ALU waits indefinitely.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   kbEN       in   key strobe (level); one event per 0->1 edge
//   pressedkey in   key code: 0-9 digit, A '=', B AC, C +, D -, E *, F /
//   ALUNum1    out  operand A, packed BCD
//   ALUNum2    out  operand B, packed BCD
//   ALUOp      out  operator key code
//   ALUstart   out  one-cycle request pulse
//   ALUdone    in   one-cycle completion pulse
//   ALUres     in   result, valid with ALUdone
//   ALUerr     in   overflow / divide-by-zero flag, valid with ALUdone
//   Display    out  packed BCD display value
//   busy       out  high while an ALU operation (or a drained one) is open
//   err        out  high in the error state
// ---------------------------------------------------------------------------
module calc_seq #(
    parameter int                  DIGITS   = 4,
    parameter logic [4*DIGITS-1:0] ERR_CODE = {DIGITS{4'hE}},
    parameter int                  TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                kbEN,
    input  logic [3:0]          pressedkey,
    output logic [4*DIGITS-1:0] ALUNum1,
    output logic [4*DIGITS-1:0] ALUNum2,
    output logic [3:0]          ALUOp,
    output logic                ALUstart,
    input  logic                ALUdone,
    input  logic [4*DIGITS-1:0] ALUres,
    input  logic                ALUerr,
    output logic [4*DIGITS-1:0] Display,
    output logic                busy,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [3:0] KEY_EQ   = 4'b1010;
    localparam logic [3:0] KEY_AC   = 4'b1011;
    localparam logic [3:0] KEY_PLUS = 4'b1100;

    typedef enum logic [2:0] {
        ENTRY_A,
        ENTRY_B,
        WAIT_ALU,
        RESULT,
        ERROR
    } state_t;

    // Elaboration-time sanity check on the configuration.
    if (DIGITS < 1 || TIMEOUT < 1) begin : gParamCheck
        $error("calc_seq: DIGITS and TIMEOUT must be positive");
    end

    logic          kbEN_q;
    logic          evt_q;
    logic [3:0]    key_q;
    state_t        state_q;
    logic [W-1:0]  opA_q;
    logic [W-1:0]  opB_q;
    logic [3:0]    op_q;
    logic [3:0]    pend_q;
    logic          pendValid_q;
    logic [CW-1:0] count_q;
    logic [W-1:0]  display_q;
    logic [W-1:0]  aluNum1_q;
    logic [W-1:0]  aluNum2_q;
    logic [3:0]    aluOp_q;
    logic          aluStart_q;
    logic          drain_q;

    logic [W-1:0]  opAShift_d;
    logic [W-1:0]  opBShift_d;
    logic [CW-1:0] countInc_d;
    logic          isDigit;
    logic          isOp;
    logic          isEq;
    logic          countOk;
    logic          acEvt;
    logic          keyEvt;

    // Key strobe edge detector. The event and its key code are registered
    // so that the state machine sees a clean, single-cycle key event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbEN_q <= 1'b0;
            evt_q  <= 1'b0;
            key_q  <= 4'h0;
        end else begin
            kbEN_q <= kbEN;
            evt_q  <= kbEN & ~kbEN_q;
            key_q  <= pressedkey;
        end
    end

    // Keeping only the low W bits of {operand, digit} shifts the new digit
    // in at the least significant position and drops the top digit.
    assign opAShift_d = W'({opA_q, key_q});
    assign opBShift_d = W'({opB_q, key_q});
    assign countInc_d = count_q + CW'(1);

    assign isDigit = (key_q <= 4'd9);
    assign isOp    = (key_q[3:2] == 2'b11);
    assign isEq    = (key_q == KEY_EQ);
    assign countOk = (count_q < CW'(DIGITS));

    // AC is honoured even while draining; everything else is dropped until
    // the orphaned ALU completion has been absorbed.
    assign acEvt  = evt_q & (key_q == KEY_AC);
    assign keyEvt = evt_q & ~drain_q;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q;

    // Watchdog: held at zero outside WAIT_ALU, so it restarts on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (state_q != WAIT_ALU) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end
`endif

    // Main sequencer. AC takes priority over everything, including an
    // ALUdone in the same cycle, in which case no drain is required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ENTRY_A;
            opA_q       <= '0;
            opB_q       <= '0;
            op_q        <= KEY_PLUS;
            pend_q      <= KEY_PLUS;
            pendValid_q <= 1'b0;
            count_q     <= '0;
            display_q   <= '0;
            aluNum1_q   <= '0;
            aluNum2_q   <= '0;
            aluOp_q     <= 4'h0;
            aluStart_q  <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            aluStart_q <= 1'b0;
            if (drain_q && ALUdone) begin
                drain_q <= 1'b0;
            end
            if (acEvt) begin
                state_q     <= ENTRY_A;
                opA_q       <= '0;
                opB_q       <= '0;
                op_q        <= KEY_PLUS;
                pend_q      <= KEY_PLUS;
                pendValid_q <= 1'b0;
                count_q     <= '0;
                display_q   <= '0;
                aluNum1_q   <= '0;
                aluNum2_q   <= '0;
                aluOp_q     <= 4'h0;
                drain_q     <= (state_q == WAIT_ALU || drain_q) && !ALUdone;
            end else begin
                case (state_q)
                    ENTRY_A: begin
                        if (keyEvt && isDigit && countOk) begin
                            opA_q     <= opAShift_d;
                            count_q   <= countInc_d;
                            display_q <= opAShift_d;
                        end else if (keyEvt && isOp) begin
                            op_q    <= key_q;
                            opB_q   <= '0;
                            count_q <= '0;
                            state_q <= ENTRY_B;
                        end
                    end
                    ENTRY_B: begin
                        if (keyEvt && isDigit && countOk) begin
                            opB_q     <= opBShift_d;
                            count_q   <= countInc_d;
                            display_q <= opBShift_d;
                        end else if (keyEvt && isOp && count_q == '0) begin
                            op_q <= key_q;
                        end else if (keyEvt && (isOp || isEq) && count_q != '0) begin
                            // An operator here both issues the pending
                            // operation and remembers itself for the next one.
                            aluNum1_q   <= opA_q;
                            aluNum2_q   <= opB_q;
                            aluOp_q     <= op_q;
                            aluStart_q  <= 1'b1;
                            pend_q      <= key_q;
                            pendValid_q <= isOp;
                            state_q     <= WAIT_ALU;
                        end
                    end
                    WAIT_ALU: begin
                        if (ALUdone && ALUerr) begin
                            display_q   <= ERR_CODE;
                            pendValid_q <= 1'b0;
                            state_q     <= ERROR;
                        end else if (ALUdone) begin
                            opA_q     <= ALUres;
                            display_q <= ALUres;
                            if (pendValid_q) begin
                                op_q        <= pend_q;
                                opB_q       <= '0;
                                count_q     <= '0;
                                pendValid_q <= 1'b0;
                                state_q     <= ENTRY_B;
                            end else begin
                                state_q <= RESULT;
                            end
                        end
`ifdef CALC_SEQ_TIMEOUT_EN
                        else if (timer_q == TW'(TIMEOUT - 1)) begin
                            display_q   <= ERR_CODE;
                            pendValid_q <= 1'b0;
                            drain_q     <= 1'b1;
                            state_q     <= ERROR;
                        end
`endif
                    end
                    RESULT: begin
                        if (keyEvt && isDigit) begin
                            opA_q     <= W'(key_q);
                            count_q   <= CW'(1);
                            display_q <= W'(key_q);
                            state_q   <= ENTRY_A;
                        end else if (keyEvt && isOp) begin
                            op_q    <= key_q;
                            opB_q   <= '0;
                            count_q <= '0;
                            state_q <= ENTRY_B;
                        end else if (keyEvt && isEq) begin
                            // Repeat-equals: reuse the last operator and opB.
                            aluNum1_q   <= opA_q;
                            aluNum2_q   <= opB_q;
                            aluOp_q     <= op_q;
                            aluStart_q  <= 1'b1;
                            pendValid_q <= 1'b0;
                            state_q     <= WAIT_ALU;
                        end
                    end
                    ERROR: begin
                    end
                    default: begin
                        state_q <= ENTRY_A;
                    end
                endcase
            end
        end
    end

    assign ALUNum1  = aluNum1_q;
    assign ALUNum2  = aluNum2_q;
    assign ALUOp    = aluOp_q;
    assign ALUstart = aluStart_q;
    assign Display  = display_q;
    assign busy     = (state_q == WAIT_ALU) | drain_q;
    assign err      = (state_q == ERROR);

endmodule

// File: tb/tb_calc_seq.sv
// ---------------------------------------------------------------------------
// tb_calc_seq
// Self-checking bench for calc_seq (DIGITS=4). A behavioural ALU answers
// each ALUstart from a scoreboard queue of expected requests; each queue
// entry also carries the result, error flag and latency the ALU returns.
// ---------------------------------------------------------------------------
module tb_calc_seq;

    localparam int W = 16;

    localparam logic [3:0] K_EQ  = 4'hA;
    localparam logic [3:0] K_AC  = 4'hB;
    localparam logic [3:0] K_ADD = 4'hC;
    localparam logic [3:0] K_SUB = 4'hD;
    localparam logic [3:0] K_MUL = 4'hE;
    localparam logic [3:0] K_DIV = 4'hF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         kbEN;
    logic [3:0]   pressedkey;
    logic [W-1:0] ALUNum1;
    logic [W-1:0] ALUNum2;
    logic [3:0]   ALUOp;
    logic         ALUstart;
    logic         ALUdone;
    logic [W-1:0] ALUres;
    logic         ALUerr;
    logic [W-1:0] Display;
    logic         busy;
    logic         err;

    typedef struct {
        logic [W-1:0] num1;
        logic [W-1:0] num2;
        logic [3:0]   op;
        logic [W-1:0] res;
        logic         aluErr;
        int           lat;
    } aluTxn_t;

    aluTxn_t sbQueue[$];
    int testsRun    = 0;
    int testsFailed = 0;

    calc_seq #(.DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kbEN       (kbEN),
        .pressedkey (pressedkey),
        .ALUNum1    (ALUNum1),
        .ALUNum2    (ALUNum2),
        .ALUOp      (ALUOp),
        .ALUstart   (ALUstart),
        .ALUdone    (ALUdone),
        .ALUres     (ALUres),
        .ALUerr     (ALUerr),
        .Display    (Display),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: checks each request against the scoreboard, then
    // answers after the entry's latency (latency 0 means never answer).
    initial begin : aluModel
        aluTxn_t t;
        ALUdone = 1'b0;
        ALUres  = '0;
        ALUerr  = 1'b0;
        forever begin
            @(negedge clk);
            if (ALUstart === 1'b1) begin
                testsRun++;
                if (sbQueue.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL alu_unexpected_start: got ALUstart=1 with Num1=%h Num2=%h Op=%h, required no request",
                             ALUNum1, ALUNum2, ALUOp);
                end else begin
                    t = sbQueue.pop_front();
                    if (ALUNum1 !== t.num1 || ALUNum2 !== t.num2 || ALUOp !== t.op) begin
                        testsFailed++;
                        $display("[TB] FAIL alu_request: got %h %h op %h, required %h %h op %h",
                                 ALUNum1, ALUNum2, ALUOp, t.num1, t.num2, t.op);
                    end
                    @(negedge clk);
                    testsRun++;
                    if (ALUstart !== 1'b0) begin
                        testsFailed++;
                        $display("[TB] FAIL alu_start_pulse: got ALUstart=%b one cycle later, required 0", ALUstart);
                    end
                    if (t.lat > 0) begin
                        repeat (t.lat - 2) begin
                            @(negedge clk);
                        end
                        testsRun++;
                        if (busy !== 1'b1) begin
                            testsFailed++;
                            $display("[TB] FAIL busy_while_wait: got busy=%b, required 1", busy);
                        end
                        ALUdone = 1'b1;
                        ALUres  = t.res;
                        ALUerr  = t.aluErr;
                        @(negedge clk);
                        ALUdone = 1'b0;
                        ALUerr  = 1'b0;
                        testsRun++;
                        if (busy !== 1'b0) begin
                            testsFailed++;
                            $display("[TB] FAIL busy_after_done: got busy=%b, required 0", busy);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] aborted");
    end

    task automatic pushTxn(input logic [W-1:0] n1, input logic [W-1:0] n2, input logic [3:0] op,
                           input logic [W-1:0] res, input logic aluErr, input int lat);
        aluTxn_t t;
        t.num1   = n1;
        t.num2   = n2;
        t.op     = op;
        t.res    = res;
        t.aluErr = aluErr;
        t.lat    = lat;
        sbQueue.push_back(t);
    endtask

    task automatic applyStimulus(input logic [3:0] key, input int hold);
        @(negedge clk);
        pressedkey = key;
        kbEN       = 1'b1;
        repeat (hold) @(negedge clk);
        kbEN = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s_idle: got busy=%b after 200 cycles, required 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        kbEN       = 1'b0;
        pressedkey = 4'h0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (Display !== 16'h0000 || ALUstart !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got Display=%h start=%b busy=%b err=%b, required 0000 0 0 0",
                     Display, ALUstart, busy, err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (Display !== 16'h0000 || ALUNum1 !== 16'h0000 || ALUNum2 !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got Display=%h Num1=%h Num2=%h, required 0000 0000 0000",
                     Display, ALUNum1, ALUNum2);
        end
    endtask

    task automatic test_basic_add();
        pushTxn(16'h0001, 16'h0001, K_ADD, 16'h0002, 1'b0, 3);
        applyStimulus(4'd1, 2);
        applyStimulus(K_ADD, 2);
        applyStimulus(4'd1, 2);
        applyStimulus(K_EQ, 2);
        waitIdle("basic_add");
        testsRun++;
        if (Display !== 16'h0002) begin
            testsFailed++;
            $display("[TB] FAIL basic_add_display: got %h, required 0002", Display);
        end
    endtask

    task automatic test_repeat_equals();
        applyStimulus(K_AC, 2);
        pushTxn(16'h0012, 16'h0001, K_ADD, 16'h0013, 1'b0, 3);
        pushTxn(16'h0013, 16'h0001, K_ADD, 16'h0014, 1'b0, 5);
        pushTxn(16'h0014, 16'h0001, K_ADD, 16'h0015, 1'b0, 2);
        applyStimulus(4'd1, 2);
        applyStimulus(4'd2, 2);
        applyStimulus(K_ADD, 2);
        applyStimulus(4'd1, 2);
        applyStimulus(K_EQ, 2);
        waitIdle("repeat1");
        testsRun++;
        if (Display !== 16'h0013) begin
            testsFailed++;
            $display("[TB] FAIL repeat_first: got %h, required 0013", Display);
        end
        applyStimulus(K_EQ, 2);
        waitIdle("repeat2");
        testsRun++;
        if (Display !== 16'h0014) begin
            testsFailed++;
            $display("[TB] FAIL repeat_second: got %h, required 0014", Display);
        end
        applyStimulus(K_EQ, 2);
        waitIdle("repeat3");
        testsRun++;
        if (Display !== 16'h0015) begin
            testsFailed++;
            $display("[TB] FAIL repeat_third: got %h, required 0015", Display);
        end
    endtask

    task automatic test_chain();
        applyStimulus(K_AC, 5);
        pushTxn(16'h0002, 16'h0003, K_ADD, 16'h0005, 1'b0, 3);
        pushTxn(16'h0005, 16'h0004, K_MUL, 16'h0020, 1'b0, 4);
        applyStimulus(4'd2, 5);
        applyStimulus(K_ADD, 5);
        applyStimulus(4'd3, 5);
        applyStimulus(K_MUL, 5);
        waitIdle("chain1");
        testsRun++;
        if (Display !== 16'h0005) begin
            testsFailed++;
            $display("[TB] FAIL chain_intermediate: got %h, required 0005", Display);
        end
        applyStimulus(4'd4, 5);
        testsRun++;
        if (Display !== 16'h0004) begin
            testsFailed++;
            $display("[TB] FAIL chain_operand: got %h, required 0004", Display);
        end
        applyStimulus(K_EQ, 5);
        waitIdle("chain2");
        testsRun++;
        if (Display !== 16'h0020) begin
            testsFailed++;
            $display("[TB] FAIL chain_final: got %h, required 0020", Display);
        end
    endtask

    task automatic test_digit_limit();
        applyStimulus(K_AC, 2);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(4'(i), 2);
        end
        testsRun++;
        if (Display !== 16'h1234) begin
            testsFailed++;
            $display("[TB] FAIL digit_limit: got %h, required 1234", Display);
        end
        pushTxn(16'h1234, 16'h0005, K_SUB, 16'h1229, 1'b0, 3);
        applyStimulus(K_ADD, 2);
        applyStimulus(K_SUB, 2);
        applyStimulus(4'd5, 2);
        applyStimulus(K_EQ, 2);
        waitIdle("op_replace");
        testsRun++;
        if (Display !== 16'h1229) begin
            testsFailed++;
            $display("[TB] FAIL op_replace_result: got %h, required 1229", Display);
        end
    endtask

    task automatic test_error();
        applyStimulus(K_AC, 2);
        pushTxn(16'h0012, 16'h0000, K_DIV, 16'h0000, 1'b1, 4);
        applyStimulus(4'd1, 2);
        applyStimulus(4'd2, 2);
        applyStimulus(K_DIV, 2);
        applyStimulus(4'd0, 2);
        applyStimulus(K_EQ, 2);
        waitIdle("error");
        testsRun++;
        if (err !== 1'b1 || Display !== 16'hEEEE) begin
            testsFailed++;
            $display("[TB] FAIL error_enter: got err=%b Display=%h, required 1 EEEE", err, Display);
        end
        applyStimulus(4'd7, 2);
        testsRun++;
        if (err !== 1'b1 || Display !== 16'hEEEE) begin
            testsFailed++;
            $display("[TB] FAIL error_sticky: got err=%b Display=%h, required 1 EEEE", err, Display);
        end
        applyStimulus(K_AC, 2);
        testsRun++;
        if (err !== 1'b0 || Display !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL error_clear: got err=%b Display=%h, required 0 0000", err, Display);
        end
        applyStimulus(4'd3, 2);
        testsRun++;
        if (Display !== 16'h0003) begin
            testsFailed++;
            $display("[TB] FAIL error_entry_a: got %h, required 0003", Display);
        end
    endtask

    task automatic test_back_to_back_drain();
        applyStimulus(K_AC, 2);
        pushTxn(16'h0005, 16'h0006, K_ADD, 16'h0011, 1'b0, 20);
        applyStimulus(4'd5, 2);
        applyStimulus(K_ADD, 2);
        applyStimulus(4'd6, 2);
        applyStimulus(K_EQ, 2);
        applyStimulus(K_AC, 2);
        testsRun++;
        if (busy !== 1'b1 || Display !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL drain_busy: got busy=%b Display=%h, required 1 0000", busy, Display);
        end
        applyStimulus(4'd9, 2);
        waitIdle("drain");
        testsRun++;
        if (Display !== 16'h0000 || err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL drain_discard: got Display=%h err=%b, required 0000 0", Display, err);
        end
        applyStimulus(4'd4, 2);
        testsRun++;
        if (Display !== 16'h0004) begin
            testsFailed++;
            $display("[TB] FAIL drain_recover: got %h, required 0004", Display);
        end
    endtask

`ifdef CALC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        applyStimulus(K_AC, 2);
        pushTxn(16'h0001, 16'h0002, K_ADD, 16'h0003, 1'b0, 0);
        applyStimulus(4'd1, 2);
        applyStimulus(K_ADD, 2);
        applyStimulus(4'd2, 2);
        applyStimulus(K_EQ, 2);
        n = 0;
        while (err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (err !== 1'b1 || Display !== 16'hEEEE || n < 55) begin
            testsFailed++;
            $display("[TB] FAIL timeout_error: got err=%b Display=%h after %0d cycles, required 1 EEEE after about 64",
                     err, Display, n);
        end
    endtask
`endif

    task automatic test_async_reset();
        rst_n = 1'b1;
        applyStimulus(K_AC, 2);
        applyStimulus(4'd1, 2);
        applyStimulus(4'd2, 2);
        testsRun++;
        if (Display !== 16'h0012) begin
            testsFailed++;
            $display("[TB] FAIL async_pre: got %h, required 0012", Display);
        end
        #2;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (Display !== 16'h0000 || ALUNum1 !== 16'h0000 || ALUNum2 !== 16'h0000 ||
            ALUstart !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got Display=%h Num1=%h Num2=%h start=%b busy=%b err=%b, required all 0",
                     Display, ALUNum1, ALUNum2, ALUstart, busy, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkOutput();
        testsRun++;
        if (sbQueue.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drained: got %0d outstanding requests, required 0", sbQueue.size());
        end
    endtask

    initial begin : main
        test_reset();
        test_basic_add();
        test_repeat_equals();
        test_chain();
        test_digit_limit();
        test_error();
        test_back_to_back_drain();
`ifdef CALC_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        checkOutput();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
